// File: rtl/kp_entry_ctrl.sv
// kp_entry_ctrl: keypad scan-code driven entry of a two-operand BCD expression.
// Ports:
//   clk         - system clock, rising edge
//   rst_n       - asynchronous active-low reset
//   last_change - scan code of the most recent key event
//   key_valid   - one-cycle strobe marking a new make code on last_change
//   op_a, op_b  - BCD operands, least significant digit in [3:0]
//   op_code     - 0 none, 1 add, 2 subtract, 3 multiply
//   disp_bcd    - operand being edited (op_b in S_B, otherwise op_a)
//   state       - 0 S_A, 1 S_B, 2 S_DONE
//   entry_done  - one-cycle pulse when an expression completes
module kp_entry_ctrl #(
    parameter int DIGITS = 2,
    parameter int BW     = 4 * DIGITS
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [8:0]    last_change,
    input  logic          key_valid,
    output logic [BW-1:0] op_a,
    output logic [BW-1:0] op_b,
    output logic [1:0]    op_code,
    output logic [BW-1:0] disp_bcd,
    output logic [1:0]    state,
    output logic          entry_done
);
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] MAXC = CW'(DIGITS);
    localparam logic [CW-1:0] ONE = CW'(1);
    localparam logic [1:0] S_A = 2'd0, S_B = 2'd1, S_DONE = 2'd2, S_BAD = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [BW-1:0] op_a_q, op_a_d, op_b_q, op_b_d, disp_q, disp_d;
    logic [1:0]    op_code_q, op_code_d;
    logic [CW-1:0] a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
    logic          done_q, done_d;
    logic          is_dig, is_op, is_ent, is_bs, is_clr;
    logic [3:0]    dig;
    logic [1:0]    opc;

    always_comb begin
        is_dig = 1'b1;
        dig    = 4'd0;
        case (last_change)
            9'h070: dig = 4'd0;
            9'h069: dig = 4'd1;
            9'h072: dig = 4'd2;
            9'h07A: dig = 4'd3;
            9'h06B: dig = 4'd4;
            9'h073: dig = 4'd5;
            9'h074: dig = 4'd6;
            9'h06C: dig = 4'd7;
            9'h075: dig = 4'd8;
            9'h07D: dig = 4'd9;
            default: is_dig = 1'b0;
        endcase
        is_op  = last_change == 9'h079 || last_change == 9'h07B || last_change == 9'h07C;
        opc    = last_change == 9'h079 ? 2'd1 : last_change == 9'h07B ? 2'd2 : 2'd3;
        is_ent = last_change == 9'h05A;
        is_bs  = last_change == 9'h066;
        is_clr = last_change == 9'h076;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_A;
            op_a_q    <= '0;
            op_b_q    <= '0;
            op_code_q <= 2'd0;
            a_cnt_q   <= '0;
            b_cnt_q   <= '0;
            disp_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            op_code_q <= op_code_d;
            a_cnt_q   <= a_cnt_d;
            b_cnt_q   <= b_cnt_d;
            disp_q    <= disp_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        op_code_d = op_code_q;
        a_cnt_d   = a_cnt_q;
        b_cnt_d   = b_cnt_q;
        // The unused encoding recovers exactly like a clear key.
        if (state_q == S_BAD || (key_valid && is_clr)) begin
            state_d   = S_A;
            op_a_d    = '0;
            op_b_d    = '0;
            op_code_d = 2'd0;
            a_cnt_d   = '0;
            b_cnt_d   = '0;
        end else if (key_valid) begin
            case (state_q)
                S_A: begin
                    if (is_dig && a_cnt_q != MAXC) begin
                        op_a_d  = (op_a_q << 4) | BW'(dig);
                        a_cnt_d = a_cnt_q + ONE;
                    end else if (is_bs && a_cnt_q != '0) begin
                        op_a_d  = op_a_q >> 4;
                        a_cnt_d = a_cnt_q - ONE;
                    end else if (is_op && a_cnt_q != '0) begin
                        op_code_d = opc;
                        state_d   = S_B;
                    end
                end
                S_B: begin
                    if (is_dig && b_cnt_q != MAXC) begin
                        op_b_d  = (op_b_q << 4) | BW'(dig);
                        b_cnt_d = b_cnt_q + ONE;
                    end else if (is_bs && b_cnt_q != '0) begin
                        op_b_d  = op_b_q >> 4;
                        b_cnt_d = b_cnt_q - ONE;
                    end else if (is_bs) begin
                        op_code_d = 2'd0;
                        state_d   = S_A;
                    end else if (is_op && b_cnt_q == '0) begin
                        op_code_d = opc;
                    end else if (is_ent && b_cnt_q != '0) begin
                        state_d = S_DONE;
                    end
                end
                default: begin
                    // A digit after a finished expression starts a fresh one.
                    if (is_dig) begin
                        op_a_d    = BW'(dig);
                        a_cnt_d   = ONE;
                        op_b_d    = '0;
                        b_cnt_d   = '0;
                        op_code_d = 2'd0;
                        state_d   = S_A;
                    end
                end
            endcase
        end
    end

    always_comb begin
        disp_d = state_d == S_B ? op_b_d : op_a_d;
        done_d = state_q == S_B && state_d == S_DONE;
    end

    assign op_a       = op_a_q;
    assign op_b       = op_b_q;
    assign op_code    = op_code_q;
    assign disp_bcd   = disp_q;
    assign state      = state_q;
    assign entry_done = done_q;
endmodule

// File: tb/tb_kp_entry_ctrl.sv
// tb_kp_entry_ctrl: directed-vector bench for kp_entry_ctrl at DIGITS=2 and DIGITS=4.
module tb_kp_entry_ctrl;
    localparam logic [8:0] K1 = 9'h069, K2 = 9'h072, K3 = 9'h07A, K4 = 9'h06B, K5 = 9'h073,
                           K6 = 9'h074, K7 = 9'h06C, K8 = 9'h075, K9 = 9'h07D,
                           ADD = 9'h079, SUB = 9'h07B, MUL = 9'h07C, ENT = 9'h05A,
                           BS = 9'h066, CLR = 9'h076;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [8:0]  last_change = 9'h000;
    logic        key_valid = 1'b0;
    logic [7:0]  a2, b2, d2;
    logic [15:0] a4, b4, d4;
    logic [1:0]  oc2, st2, oc4, st4;
    logic        dn2, dn4;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    kp_entry_ctrl dut (
        .clk(clk), .rst_n(rst_n), .last_change(last_change), .key_valid(key_valid),
        .op_a(a2), .op_b(b2), .op_code(oc2), .disp_bcd(d2), .state(st2), .entry_done(dn2)
    );

    kp_entry_ctrl #(.DIGITS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .last_change(last_change), .key_valid(key_valid),
        .op_a(a4), .op_b(b4), .op_code(oc4), .disp_bcd(d4), .state(st4), .entry_done(dn4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic press(input logic [8:0] code);
        @(negedge clk);
        last_change = code;
        key_valid   = 1'b1;
        @(negedge clk);
        key_valid   = 1'b0;
    endtask

    task automatic chk2(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] oc, input logic [1:0] st, input logic [7:0] d);
        check({tag, ".a"}, 32'(a2), 32'(a));
        check({tag, ".b"}, 32'(b2), 32'(b));
        check({tag, ".op"}, 32'(oc2), 32'(oc));
        check({tag, ".st"}, 32'(st2), 32'(st));
        check({tag, ".disp"}, 32'(d2), 32'(d));
    endtask

    initial begin
        #2;
        chk2("rst2", 8'h00, 8'h00, 2'd0, 2'd0, 8'h00);
        check("rst.done", 32'(dn2), 32'd0);
        check("rst4.a", 32'(a4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1 2 + 3 enter
        press(K1); press(K2);
        chk2("s1.ab", 8'h12, 8'h00, 2'd0, 2'd0, 8'h12);
        press(ADD);
        chk2("s1.add", 8'h12, 8'h00, 2'd1, 2'd1, 8'h00);
        press(K3);
        check("s1.disp3", 32'(d2), 32'h03);
        press(ENT);
        chk2("s1.ent", 8'h12, 8'h03, 2'd1, 2'd2, 8'h12);
        check("s1.done_hi", 32'(dn2), 32'd1);
        check("s1.done4_hi", 32'(dn4), 32'd1);
        @(negedge clk);
        check("s1.done_lo", 32'(dn2), 32'd0);
        press(ADD); press(BS); press(ENT);
        chk2("s1.done_ign", 8'h12, 8'h03, 2'd1, 2'd2, 8'h12);
        check("s1.done_ign_pulse", 32'(dn2), 32'd0);

        // new digit after completion
        press(K5);
        chk2("s5.new", 8'h05, 8'h00, 2'd0, 2'd0, 8'h05);

        // digit cap and backspace
        press(CLR);
        chk2("s2.clr", 8'h00, 8'h00, 2'd0, 2'd0, 8'h00);
        press(K4); press(K5); press(K6);
        check("s2.cap2", 32'(a2), 32'h45);
        check("s2.cap4", 32'(a4), 32'h456);
        press(9'h01C); press(ENT);
        chk2("s2.ign", 8'h45, 8'h00, 2'd0, 2'd0, 8'h45);
        @(negedge clk);
        last_change = K9;
        repeat (3) @(negedge clk);
        check("s2.nokv", 32'(a2), 32'h45);
        press(BS);
        check("s2.bs2", 32'(a2), 32'h04);
        check("s2.bs4", 32'(a4), 32'h45);

        // operator replacement while op_b empty
        press(CLR);
        press(K7); press(ADD); press(SUB); press(MUL);
        check("s3.repl", 32'(oc2), 32'd3);
        press(K8); press(ADD);
        chk2("s3.end", 8'h07, 8'h08, 2'd3, 2'd1, 8'h08);

        // backspace back into S_A and down to empty
        press(CLR);
        press(K9); press(ADD); press(BS);
        chk2("s4.back", 8'h09, 8'h00, 2'd0, 2'd0, 8'h09);
        press(BS);
        chk2("s4.empty", 8'h00, 8'h00, 2'd0, 2'd0, 8'h00);
        press(ADD); press(BS);
        check("s4.op_ign", 32'(st2), 32'd0);
        press(K2); press(ADD); press(ENT);
        check("s4.ent_ign", 32'(st2), 32'd1);
        check("s4.ent_ign_done", 32'(dn2), 32'd0);

        // clear in S_DONE
        press(K1); press(ENT);
        check("s5.st_done", 32'(st2), 32'd2);
        press(CLR);
        chk2("s5.clr", 8'h00, 8'h00, 2'd0, 2'd0, 8'h00);

        // DIGITS=4 entry, async reset during S_B, idle hold
        press(K1); press(K2); press(K3); press(K4); press(K5);
        check("s6.cap4", 32'(a4), 32'h1234);
        press(ADD); press(K6);
        check("s6.st4", 32'(st4), 32'd1);
        check("s6.disp4", 32'(d4), 32'h6);
        #2 rst_n = 1'b0;
        #1;
        check("s6.ar.a", 32'(a4), 32'd0);
        check("s6.ar.b", 32'(b4), 32'd0);
        check("s6.ar.op", 32'(oc4), 32'd0);
        check("s6.ar.st", 32'(st4), 32'd0);
        check("s6.ar.disp", 32'(d4), 32'd0);
        check("s6.ar.a2", 32'(a2), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_change = K7;
        repeat (10) @(negedge clk);
        check("s6.idle.a", 32'(a4), 32'd0);
        check("s6.idle.st", 32'(st4), 32'd0);
        check("s6.idle.done", 32'(dn4), 32'd0);
        press(K7);
        check("s6.first.a", 32'(a4), 32'h7);
        check("s6.first.st", 32'(st4), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/kp_entry_ctrl.md
KP_ENTRY_CTRL -- requirements
Module: kp_entry_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 2, giving the maximum BCD digits per operand (legal range 1..8).
REQ-002 SHALL have parameter BW, default 4*DIGITS, giving the BCD operand width; BW is derived and is not overridden independently.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port last_change, input, 9 bits: scan code of the most recent key event.
REQ-006 SHALL have port key_valid, input, 1 bit: single-cycle strobe; when high, last_change holds a new key-press (make) code.
REQ-007 SHALL have port op_a, output, BW bits: operand A in BCD, least significant digit in [3:0].
REQ-008 SHALL have port op_b, output, BW bits: operand B in BCD, same layout as op_a.
REQ-009 SHALL have port op_code, output, 2 bits: 0 = none, 1 = add, 2 = subtract, 3 = multiply.
REQ-010 SHALL have port disp_bcd, output, BW bits: the operand currently being edited (op_b in S_B, otherwise op_a).
REQ-011 SHALL have port state, output, 2 bits: 0 = S_A, 1 = S_B, 2 = S_DONE.
REQ-012 SHALL have port entry_done, output, 1 bit: one-cycle pulse when an expression completes.

Function
REQ-013 SHALL decode last_change internally as follows: 0x70->0, 0x69->1, 0x72->2, 0x7A->3, 0x6B->4, 0x73->5, 0x74->6, 0x6C->7, 0x75->8, 0x7D->9; 0x79 = add; 0x7B = subtract; 0x7C = multiply; 0x5A = enter; 0x66 = backspace; 0x76 = clear; all other codes ignored.
REQ-014 SHALL act only in cycles with key_valid=1; with key_valid=0 all registers hold.
REQ-015 SHALL make every effect of an accepted key visible on outputs on the clock edge that samples key_valid (one-cycle latency); all outputs are registered.
REQ-016 SHALL, on a digit key, shift the edited operand left one digit and insert the new digit at [3:0], incrementing the digit count (a_cnt or b_cnt, each range 0..DIGITS).
REQ-017 SHALL ignore a digit key when the edited operand's count already equals DIGITS; no wrap, no truncation of existing digits.
REQ-018 SHALL, on backspace with count > 0, shift the edited operand right one digit, fill the top digit with 0, and decrement the count.
REQ-019 SHALL, in S_A: on an operator key with a_cnt > 0, set op_code and go to S_B; ignore an operator key when a_cnt = 0; ignore enter; ignore backspace when a_cnt = 0.
REQ-020 SHALL, in S_B: on an operator key with b_cnt = 0, replace op_code; ignore an operator key when b_cnt > 0.
REQ-021 SHALL, in S_B: on enter with b_cnt > 0, go to S_DONE and pulse entry_done on that same edge; ignore enter when b_cnt = 0.
REQ-022 SHALL, in S_B: on backspace with b_cnt = 0, set op_code=0 and return to S_A with op_a and a_cnt unchanged.
REQ-023 SHALL, in S_DONE: hold op_a, op_b and op_code.
REQ-024 SHALL, in S_DONE, on a digit key: clear op_b, b_cnt and op_code, load op_a with that digit, set a_cnt=1, and go to S_A.
REQ-025 SHALL, in S_DONE, ignore operator, enter and backspace keys.
REQ-026 SHALL, in any state, on a clear key: zero op_a, op_b, op_code, a_cnt and b_cnt, and go to S_A.
REQ-027 SHALL drive entry_done high for exactly one cycle per completion and low at all other times.
REQ-028 SHALL never create an illegal state encoding (3); if state 3 is reached, go to S_A with all registers cleared on the next edge.

Reset
REQ-029 SHALL, while rst_n=0, immediately force state=S_A, op_a=0, op_b=0, op_code=0, disp_bcd=0, entry_done=0, a_cnt=0, b_cnt=0, regardless of clk.
REQ-030 SHALL, on rst_n assertion mid-entry (any state, including the entry_done cycle), abandon the entry; the first key_valid after rst_n release is processed in S_A.

Verification
REQ-031 SHALL be verified with scenario: DIGITS=2; keys 1,2,add,3,enter -> op_a=0x12, op_code=1, op_b=0x03, state=2, entry_done high exactly one cycle.
REQ-032 SHALL be verified with scenario: DIGITS=2; keys 4,5,6 -> op_a=0x45, a_cnt=2; then backspace -> op_a=0x04.
REQ-033 SHALL be verified with scenario: keys 7,add,subtract,multiply,8,add -> op_code=3, op_b=0x08; the trailing add is ignored.
REQ-034 SHALL be verified with scenario: key 9, add, backspace, backspace -> state=0, op_code=0, op_a=0x00, a_cnt=0.
REQ-035 SHALL be verified with scenario: expression done, then key 5 -> state=0, op_a=0x05, op_b=0, op_code=0; alternatively clear in S_DONE -> all zero.
REQ-036 SHALL be verified with scenario: DIGITS=4; rst_n pulsed low asynchronously between clk edges during S_B -> outputs zero before the next edge; key_valid held low for 10 cycles -> no output changes.
